// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared execute/writeback types: the functional-unit result record and
// the default number of units feeding the common data bus.
package rv32i_types;

   localparam int CDB_NUM_FU = 4;

   typedef struct packed {
      logic [31:0] register_value;
      logic [5:0]  rd_paddr;
      logic [4:0]  rob_idx;
      logic        ready_for_writeback;
   } fu_output_t;

endpackage

// File: rtl/cdb_writeback_arbiter_fifo.sv
// Per-unit writeback buffer: a small circular FIFO whose occupancy count
// drives the unit's backpressure in the arbiter.
module wb_fifo
   import rv32i_types::*;
#(
   parameter int  DEPTH     = 2,
   parameter type payload_t = fu_output_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  payload_t               din,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output payload_t               head
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

   payload_t      mem [DEPTH];
   logic [PW-1:0] head_ptr;
   logic [PW-1:0] tail_ptr;

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);
   assign head  = mem[head_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            mem[tail_ptr] <= din;
            tail_ptr      <= tail_ptr + 1'b1;
         end
         if (pop) begin
            head_ptr <= head_ptr + 1'b1;
         end
         count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
      end
   end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Buffers functional-unit results per unit and broadcasts one per cycle on
// the CDB, choosing among non-empty buffers in round-robin order.
module cdb_writeback_arbiter
   import rv32i_types::*;
#(
   parameter  int NUM_FU     = CDB_NUM_FU,
   parameter  int FIFO_DEPTH = 2,
   localparam int SRC_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  fu_output_t        fu_result [NUM_FU],
   output logic [NUM_FU-1:0] fu_ready,
   output logic              cdb_valid,
   output fu_output_t        cdb_out,
   output logic [SRC_W-1:0]  cdb_src
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [SRC_W:0] NUM_FU_C = (SRC_W + 1)'(NUM_FU);

   logic [NUM_FU-1:0] push;
   logic [NUM_FU-1:0] pop;
   logic [NUM_FU-1:0] full;
   logic [NUM_FU-1:0] empty;
   logic [CW-1:0]     counts [NUM_FU];
   fu_output_t        heads  [NUM_FU];

   logic [SRC_W-1:0]  rr_ptr;
   logic [SRC_W-1:0]  winner;
   logic [SRC_W-1:0]  next_rr;
   logic              found;
   logic              grant;
   logic [SRC_W:0]    sum;
   logic [SRC_W:0]    after_winner;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      assign fu_ready[i] = (counts[i] < DEPTH_C) & ~rst & ~flush;
      assign push[i]     = fu_result[i].ready_for_writeback & fu_ready[i];
      assign pop[i]      = grant & (winner == SRC_W'(i));

      wb_fifo #(
         .DEPTH     (FIFO_DEPTH),
         .payload_t (fu_output_t)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .clear (flush),
         .push  (push[i]),
         .pop   (pop[i]),
         .din   (fu_result[i]),
         .full  (full[i]),
         .empty (empty[i]),
         .count (counts[i]),
         .head  (heads[i])
      );

      a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(push[i] && full[i]));
   end

   // Rotating priority: walk NUM_FU offsets from rr_ptr; first non-empty buffer wins.
   always_comb begin
      found        = 1'b0;
      winner       = rr_ptr;
      sum          = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         sum = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
         if (sum >= NUM_FU_C) begin
            sum = sum - NUM_FU_C;
         end
         if (!found && !empty[sum[SRC_W-1:0]]) begin
            found  = 1'b1;
            winner = sum[SRC_W-1:0];
         end
      end
      after_winner = {1'b0, winner} + 1'b1;
      if (after_winner >= NUM_FU_C) begin
         after_winner = after_winner - NUM_FU_C;
      end
      next_rr = after_winner[SRC_W-1:0];
      grant   = found & ~rst & ~flush;
   end

   // Bus registers hold their payload when idle; only the valid flag drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid <= 1'b0;
         cdb_out   <= '0;
         cdb_src   <= '0;
         rr_ptr    <= '0;
      end else if (grant) begin
         cdb_valid <= 1'b1;
         cdb_out   <= heads[winner];
         cdb_src   <= winner;
         rr_ptr    <= next_rr;
      end else begin
         cdb_valid                     <= 1'b0;
         cdb_out.ready_for_writeback   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Self-checking bench: queue-based reference model of the writeback arbiter,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdb_writeback_arbiter;
   import rv32i_types::*;

   localparam int NUM_FU = 4;
   localparam int DEPTH  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   fu_output_t        fu_result [NUM_FU];
   logic [NUM_FU-1:0] fu_ready;
   logic              cdb_valid;
   fu_output_t        cdb_out;
   logic [1:0]        cdb_src;

   always #5 clk = ~clk;

   cdb_writeback_arbiter #(
      .NUM_FU     (NUM_FU),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .fu_result (fu_result),
      .fu_ready  (fu_ready),
      .cdb_valid (cdb_valid),
      .cdb_out   (cdb_out),
      .cdb_src   (cdb_src)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: one queue per unit plus the expected bus contents.
   fu_output_t        mq [NUM_FU][$];
   int                m_rr      = 0;
   logic              exp_valid = 1'b0;
   logic [1:0]        exp_src   = '0;
   fu_output_t        exp_data  = '0;
   bit                chk_en    = 1'b0;
   logic [NUM_FU-1:0] rdy_seen;
   bit                pend [NUM_FU];
   int                serial = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic modelStep();
      logic [NUM_FU-1:0] er;
      int w;
      for (int i = 0; i < NUM_FU; i++) begin
         er[i] = !rst && !flush && (mq[i].size() < DEPTH);
      end
      checkOutput("fu_ready", 64'(fu_ready), 64'(er));
      rdy_seen = fu_ready;
      if (rst) begin
         for (int i = 0; i < NUM_FU; i++) mq[i].delete();
         m_rr      = 0;
         exp_valid = 1'b0;
         exp_src   = '0;
         exp_data  = '0;
         chk_en    = 1'b1;
      end else if (flush) begin
         for (int i = 0; i < NUM_FU; i++) mq[i].delete();
         exp_valid = 1'b0;
      end else begin
         w = -1;
         for (int k = 0; k < NUM_FU; k++) begin
            if (w < 0 && mq[(m_rr + k) % NUM_FU].size() > 0) w = (m_rr + k) % NUM_FU;
         end
         if (w >= 0) begin
            exp_data  = mq[w].pop_front();
            exp_src   = 2'(w);
            exp_valid = 1'b1;
            m_rr      = (w + 1) % NUM_FU;
         end else begin
            exp_valid = 1'b0;
         end
      end
      for (int i = 0; i < NUM_FU; i++) begin
         if (fu_result[i].ready_for_writeback && er[i]) mq[i].push_back(fu_result[i]);
         pend[i] = fu_result[i].ready_for_writeback && !er[i];
      end
   endtask

   // Drive one cycle; a unit whose offer was refused keeps the same payload.
   task automatic applyStimulus(input logic r, input logic f, input logic [NUM_FU-1:0] mask,
                                input logic [31:0] val, input bit rnd);
      @(negedge clk);
      rst   = r;
      flush = f;
      for (int i = 0; i < NUM_FU; i++) begin
         if (mask[i]) begin
            if (!pend[i]) begin
               fu_output_t p;
               p.register_value      = rnd ? $urandom : val;
               p.rd_paddr            = rnd ? 6'($urandom) : 6'(i);
               p.rob_idx             = 5'(serial);
               p.ready_for_writeback = 1'b1;
               serial++;
               fu_result[i] = p;
            end
         end else begin
            fu_result[i].ready_for_writeback = 1'b0;
         end
      end
      #1;
      modelStep();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         checkOutput("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
         checkOutput("cdb_rfw", 64'(cdb_out.ready_for_writeback), 64'(exp_valid));
         checkOutput("cdb_src", 64'(cdb_src), 64'(exp_src));
         if (exp_valid) checkOutput("cdb_out", 64'(cdb_out), 64'(exp_data));
      end
   end

   initial begin
      int density;
      logic [NUM_FU-1:0] mask;
      logic r, f;
      rst   = 1'b1;
      flush = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
         fu_result[i] = '0;
         pend[i]      = 1'b0;
      end

      // Single result from unit 2
      applyStimulus(1, 0, '0, 0, 0);
      applyStimulus(1, 0, '0, 0, 0);
      checkOutput("rst_valid", 64'(cdb_valid), 64'h0);
      checkOutput("rst_src", 64'(cdb_src), 64'h0);
      checkOutput("rst_out", 64'(cdb_out), 64'h0);
      checkOutput("rst_ready", 64'(rdy_seen), 64'h0);
      applyStimulus(0, 0, '0, 0, 0);
      checkOutput("ready_after_rst", 64'(rdy_seen), 64'hF);
      applyStimulus(0, 0, 4'b0100, 32'hAA, 0);
      checkOutput("single_accept", 64'(rdy_seen[2]), 64'h1);
      checkOutput("single_no_bypass", 64'(cdb_valid), 64'h0);
      applyStimulus(0, 0, '0, 0, 0);
      checkOutput("single_valid", 64'(cdb_valid), 64'h1);
      checkOutput("single_src", 64'(cdb_src), 64'h2);
      checkOutput("single_value", 64'(cdb_out.register_value), 64'hAA);
      applyStimulus(0, 0, '0, 0, 0);
      checkOutput("single_done", 64'(cdb_valid), 64'h0);

      // Full contention with unit 1 backpressure
      applyStimulus(1, 0, '0, 0, 0);
      for (int c = 1; c <= 9; c++) begin
         applyStimulus(0, 0, 4'hF, 32'h100 + 32'(c), 0);
         if (c == 2) checkOutput("bp_ready_c2", 64'(rdy_seen[1]), 64'h1);
         if (c == 3) checkOutput("bp_full_c3", 64'(rdy_seen[1]), 64'h0);
         if (c == 4) checkOutput("bp_back_c4", 64'(rdy_seen[1]), 64'h1);
         if (c >= 2) begin
            checkOutput("rr_valid", 64'(cdb_valid), 64'h1);
            checkOutput("rr_src", 64'(cdb_src), 64'((c - 2) % 4));
         end
      end
      for (int c = 0; c < 10; c++) applyStimulus(0, 0, '0, 0, 0);
      checkOutput("drained", 64'(cdb_valid), 64'h0);

      // Push and pop together at count 1
      applyStimulus(1, 0, '0, 0, 0);
      applyStimulus(0, 0, 4'b0001, 32'h11, 0);
      applyStimulus(0, 0, 4'b0001, 32'h22, 0);
      checkOutput("pp_ready", 64'(rdy_seen[0]), 64'h1);
      checkOutput("pp_first", 64'(cdb_out.register_value), 64'h11);
      applyStimulus(0, 0, '0, 0, 0);
      checkOutput("pp_ready_cnt1", 64'(rdy_seen[0]), 64'h1);
      checkOutput("pp_second_valid", 64'(cdb_valid), 64'h1);
      checkOutput("pp_second", 64'(cdb_out.register_value), 64'h22);
      applyStimulus(0, 0, '0, 0, 0);
      checkOutput("pp_idle", 64'(cdb_valid), 64'h0);

      // Flush with three buffered results; unit 3's offer in the flush cycle is dropped
      applyStimulus(1, 0, '0, 0, 0);
      applyStimulus(0, 0, 4'b0111, 32'h33, 0);
      applyStimulus(0, 1, 4'b1000, 32'h34, 0);
      checkOutput("flush_ready", 64'(rdy_seen), 64'h0);
      checkOutput("flush_valid", 64'(cdb_valid), 64'h0);
      for (int c = 0; c < 4; c++) begin
         applyStimulus(0, 0, '0, 0, 0);
         checkOutput("flush_quiet", 64'(cdb_valid), 64'h0);
      end

      // Reset mid-stream: priority restarts at unit 0
      for (int c = 0; c < 3; c++) applyStimulus(0, 0, 4'hF, 32'h50 + 32'(c), 0);
      applyStimulus(1, 0, 4'hF, 32'h60, 0);
      checkOutput("mid_rst_ready", 64'(rdy_seen), 64'h0);
      checkOutput("mid_rst_valid", 64'(cdb_valid), 64'h0);
      checkOutput("mid_rst_src", 64'(cdb_src), 64'h0);
      applyStimulus(0, 0, 4'hF, 32'h61, 0);
      checkOutput("mid_rst_no_grant", 64'(cdb_valid), 64'h0);
      applyStimulus(0, 0, '0, 0, 0);
      checkOutput("mid_rst_first_valid", 64'(cdb_valid), 64'h1);
      checkOutput("mid_rst_first_src", 64'(cdb_src), 64'h0);

      // Randomized traffic with occasional flush and reset
      density = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) density = $urandom_range(10, 100);
         r = ($urandom_range(0, 199) == 0);
         f = !r && ($urandom_range(0, 49) == 0);
         for (int i = 0; i < NUM_FU; i++) begin
            mask[i] = pend[i] || ($urandom_range(0, 99) < density);
         end
         applyStimulus(r, f, mask, 0, 1);
      end
      for (int c = 0; c < 12; c++) applyStimulus(0, 0, '0, 0, 0);
      checkOutput("final_idle", 64'(cdb_valid), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
